adder_sweep_ctrl: RTL

//  Synthesizable operand sequencer and settle monitor for the ripple adders (adder_rtl/adder_gl).

---
 rtl/adder_sweep_ctrl.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/adder_sweep_ctrl.sv
// Operand sequencer and settle monitor for a ripple adder: walks every i->j input
// transition, times how long {c3,s} takes to settle, and keeps the worst case.
// Optional unsettled-phase counter enabled by `define ADDER_SWEEP_ERRCNT_EN.
module adder_sweep_ctrl #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned HOLD  = 8,
  parameter int unsigned DW    = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  output logic [WIDTH-1:0]  a_o,
  output logic [WIDTH-1:0]  b_o,
  output logic              c0_o,
  input  logic [WIDTH:0]    sum_in_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DW-1:0]     max_delay_o,
  output logic [2*WIDTH:0]  max_from_o,
  output logic [2*WIDTH:0]  max_to_o,
  output logic              err_o,
  output logic [15:0]       err_cnt_o
);

  localparam int unsigned VW = 2 * WIDTH + 1;
  localparam int unsigned SW = WIDTH + 1;
  localparam int unsigned KW = (HOLD > 2) ? $clog2(HOLD) : 1;
  localparam logic [VW-1:0] VLAST = '1;
  localparam logic [KW-1:0] KLAST = KW'(HOLD - 1);

  typedef enum logic [1:0] {IDLE, PHASE_I, PHASE_J, DONE} state_e;

  state_e          state_q, state_d;
  logic [VW-1:0]   v_q, v_d;
  logic [VW-1:0]   prev_q, prev_d;
  logic [VW-1:0]   i_q, i_d;
  logic [VW-1:0]   j_q, j_d;
  logic [KW-1:0]   k_q, k_d;
  logic [DW-1:0]   lastmis_q, lastmis_d;
  logic [DW-1:0]   maxd_q, maxd_d;
  logic [VW-1:0]   from_q, from_d;
  logic [VW-1:0]   to_q, to_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [SW-1:0]   exp_c;
  logic            mismatch_c;
  logic [DW-1:0]   dcur_c;
  logic            phase_last_c;
  logic            start_ok_c;

  assign a_o         = v_q[VW-1 -: WIDTH];
  assign b_o         = v_q[WIDTH:1];
  assign c0_o        = v_q[0];
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign max_delay_o = maxd_q;
  assign max_from_o  = from_q;
  assign max_to_o    = to_q;
  assign err_o       = err_q;

  // Compare against the operands currently on the bus; d tracks the last mismatching sample.
  assign exp_c        = SW'(a_o) + SW'(b_o) + SW'(c0_o);
  assign mismatch_c   = (sum_in_i != exp_c);
  assign dcur_c       = mismatch_c ? (DW'(k_q) + DW'(1)) : lastmis_q;
  assign phase_last_c = busy_q && (k_q == KLAST);
  assign start_ok_c   = start_i && ((state_q == IDLE) || (state_q == DONE));

  always_comb begin
    state_d   = state_q;
    v_d       = v_q;
    prev_d    = prev_q;
    i_d       = i_q;
    j_d       = j_q;
    k_d       = k_q;
    lastmis_d = lastmis_q;
    maxd_d    = maxd_q;
    from_d    = from_q;
    to_d      = to_q;
    err_d     = err_q;
    busy_d    = busy_q;
    done_d    = done_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_ok_c) begin
          state_d   = PHASE_I;
          v_d       = '0;
          prev_d    = '0;
          i_d       = '0;
          j_d       = '0;
          k_d       = '0;
          lastmis_d = '0;
          maxd_d    = '0;
          from_d    = '0;
          to_d      = '0;
          err_d     = 1'b0;
          busy_d    = 1'b1;
          done_d    = 1'b0;
        end
      end
      PHASE_I, PHASE_J: begin
        if (!phase_last_c) begin
          k_d       = k_q + KW'(1);
          lastmis_d = dcur_c;
        end else begin
          k_d       = '0;
          lastmis_d = '0;
          prev_d    = v_q;
          if (dcur_c > maxd_q) begin
            maxd_d = dcur_c;
            from_d = prev_q;
            to_d   = v_q;
          end
          if (mismatch_c) err_d = 1'b1;
          if (state_q == PHASE_I) begin
            v_d     = j_q;
            state_d = PHASE_J;
          end else if (j_q != VLAST) begin
            j_d     = j_q + VW'(1);
            v_d     = i_q;
            state_d = PHASE_I;
          end else if (i_q != VLAST) begin
            i_d     = i_q + VW'(1);
            j_d     = '0;
            v_d     = i_q + VW'(1);
            state_d = PHASE_I;
          end else begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      v_q       <= '0;
      prev_q    <= '0;
      i_q       <= '0;
      j_q       <= '0;
      k_q       <= '0;
      lastmis_q <= '0;
      maxd_q    <= '0;
      from_q    <= '0;
      to_q      <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      v_q       <= v_d;
      prev_q    <= prev_d;
      i_q       <= i_d;
      j_q       <= j_d;
      k_q       <= k_d;
      lastmis_q <= lastmis_d;
      maxd_q    <= maxd_d;
      from_q    <= from_d;
      to_q      <= to_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

`ifdef ADDER_SWEEP_ERRCNT_EN
  logic [15:0] errcnt_q;

  // Saturating count of phases still mismatching on their final sample.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      errcnt_q <= '0;
    end else if (start_ok_c) begin
      errcnt_q <= '0;
    end else if (phase_last_c && mismatch_c && (errcnt_q != 16'hFFFF)) begin
      errcnt_q <= errcnt_q + 16'd1;
    end
  end

  assign err_cnt_o = errcnt_q;
`else
  assign err_cnt_o = '0;
`endif

endmodule
